// File: rtl/cipher_pkg.sv
// Shared types and defaults for the ciphertext serializer.
// Defining CIPHER_SER_PARITY_EN adds the PARITY state to the frame FSM.
package cipher_pkg;

    localparam int WORD_W           = 10;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef CIPHER_SER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered occupancy count.
// Latency: a pushed word is visible at o_dat on the next cycle.
// Backpressure: a push while full is ignored, even with a pop on the same edge.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/cipher_serializer.sv
// Queues 10-bit ciphertext words and sends each as a start/data/[parity]/stop serial frame.
// Latency: tx falls two cycles after a push into an idle, empty block; frames run back-to-back.
// Backpressure: in_ready drops while the FIFO is full. Parity via CIPHER_SER_PARITY_EN.
module cipher_serializer
    import cipher_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BW-1:0]     r_baud;
    logic [3:0]        r_idx;
    logic [WORD_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;
`ifdef CIPHER_SER_PARITY_EN
    logic              r_par;
`endif

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_fifo_dat;
    logic              w_fifo_has;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;
    logic [BW-1:0]     w_baud_nxt;
    logic [3:0]        w_idx_nxt;
    logic [WORD_W-1:0] w_shift_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;

    assign in_ready   = !w_fifo_full;
    assign w_push     = in_valid && in_ready;
    assign w_fifo_has = !w_fifo_empty;
    assign w_bit_end  = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign tx         = r_tx;
    assign busy       = r_busy;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_dat   (in_data),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_fifo_has) w_state_nxt = START;
            START:  if (w_bit_end) w_state_nxt = DATA;
            DATA:
                if (w_bit_end && r_idx == 4'd9) begin
`ifdef CIPHER_SER_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
`ifdef CIPHER_SER_PARITY_EN
            PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
            STOP:   if (w_bit_end) w_state_nxt = w_fifo_has ? START : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // tx and busy are registered from the next-state view so they line up with r_state.
    always_comb begin
        w_pop       = w_fifo_has && (r_state == IDLE || (r_state == STOP && w_bit_end));
        w_baud_nxt  = (r_state == IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
        w_idx_nxt   = '0;
        w_shift_nxt = r_shift;
        if (r_state == DATA)
            w_idx_nxt = w_bit_end ? ((r_idx == 4'd9) ? 4'd0 : r_idx + 4'd1) : r_idx;
        if (w_pop)
            w_shift_nxt = w_fifo_dat;
        else if (r_state == DATA && w_bit_end)
            w_shift_nxt = {1'b0, r_shift[WORD_W-1:1]};
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef CIPHER_SER_PARITY_EN
            PARITY:  w_tx_nxt = r_par;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef CIPHER_SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
`ifdef CIPHER_SER_PARITY_EN
            if (w_pop) r_par <= ^w_fifo_dat;
`endif
        end
    end

endmodule

// File: tb/tb_cipher_serializer.sv
// Directed bench for cipher_serializer: single frame, FIFO fill, push on pop edge, mid-frame reset.
`timescale 1ns/1ps
module tb_cipher_serializer;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef CIPHER_SER_PARITY_EN
    localparam int NSLOT = 13;
`else
    localparam int NSLOT = 12;
`endif
    localparam int FRAME = NSLOT * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cipher_serializer #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx       (tx),
        .busy     (busy),
        .count    (count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Line level for cycle c of a frame carrying word w.
    function automatic logic exp_tx(input logic [9:0] w, input int c);
        int s;
        s = c / CPB;
        if (s == 0) return 1'b0;
        if (s <= 10) return w[s-1];
`ifdef CIPHER_SER_PARITY_EN
        if (s == 11) return ^w;
`endif
        return 1'b1;
    endfunction

    // Checks frame cycles first..last-1; the caller is sitting in cycle 'first'.
    task automatic check_frame(input logic [9:0] w, input int first, input int last);
        for (int c = first; c < last; c++) begin
            check($sformatf("tx w=%0h c=%0d", w, c), 32'(tx), 32'(exp_tx(w, c)));
            check($sformatf("busy w=%0h c=%0d", w, c), 32'(busy), 32'd1);
            tick;
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick;
        reset = 1'b0;
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

        // Single word 0x2A5; later in_data changes must not leak into the frame.
        in_valid = 1'b1;
        in_data  = 10'h2A5;
        tick;
        in_valid = 1'b0;
        in_data  = 10'h3FF;
        check("single c1 tx", 32'(tx), 32'd1);
        check("single c1 busy", 32'(busy), 32'd0);
        check("single c1 count", 32'(count), 32'd1);
        tick;
        check_frame(10'h2A5, 0, FRAME);
        check("single end busy", 32'(busy), 32'd0);
        check("single end tx", 32'(tx), 32'd1);
        check("single end count", 32'(count), 32'd0);

        // Fill: in_valid held with 001..006; 001 pops one cycle after its push.
        in_valid = 1'b1;
        in_data  = 10'h001;
        check("fill c0 ready", 32'(in_ready), 32'd1);
        tick;
        in_data = 10'h002;
        check("fill c1 count", 32'(count), 32'd1);
        tick;
        in_data = 10'h003;
        check("fill c2 count", 32'(count), 32'd1);
        check_frame(10'h001, 0, 1);
        in_data = 10'h004;
        check("fill c3 count", 32'(count), 32'd2);
        check_frame(10'h001, 1, 2);
        in_data = 10'h005;
        check("fill c4 count", 32'(count), 32'd3);
        check_frame(10'h001, 2, 3);
        in_data = 10'h006;
        check("fill c5 count", 32'(count), 32'd4);
        check("fill c5 ready", 32'(in_ready), 32'd0);
        check_frame(10'h001, 3, 40);
        check("fill hold count", 32'(count), 32'd4);
        check("fill hold ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check_frame(10'h001, 40, FRAME);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("fill frame%0d count", k), 32'(count), 32'(5 - k));
            check_frame(10'(k), 0, FRAME);
        end
        check("fill end busy", 32'(busy), 32'd0);
        check("fill end count", 32'(count), 32'd0);
        check("fill end ready", 32'(in_ready), 32'd1);

        // Push on the same edge as the end-of-STOP pop.
        in_valid = 1'b1;
        in_data  = 10'h155;
        tick;
        in_data = 10'h0F0;
        tick;
        in_valid = 1'b0;
        check("simul start count", 32'(count), 32'd1);
        check_frame(10'h155, 0, FRAME - 1);
        check("simul pre count", 32'(count), 32'd1);
        in_valid = 1'b1;
        in_data  = 10'h3C3;
        check_frame(10'h155, FRAME - 1, FRAME);
        in_valid = 1'b0;
        check("simul post count", 32'(count), 32'd1);
        check_frame(10'h0F0, 0, FRAME);
        check("simul third count", 32'(count), 32'd0);
        check_frame(10'h3C3, 0, FRAME);
        check("simul end busy", 32'(busy), 32'd0);
        check("simul end tx", 32'(tx), 32'd1);

        // Reset in the middle of DATA with three words queued.
        in_valid = 1'b1;
        in_data  = 10'h011;
        tick;
        in_data = 10'h022;
        tick;
        in_data = 10'h033;
        check_frame(10'h011, 0, 1);
        in_data = 10'h044;
        check_frame(10'h011, 1, 2);
        in_valid = 1'b0;
        check_frame(10'h011, 2, 10);
        check("rstmid pre count", 32'(count), 32'd3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rstmid tx", 32'(tx), 32'd1);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid count", 32'(count), 32'd0);
        check("rstmid ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 2 * FRAME; c++) begin
            check($sformatf("quiet tx c=%0d", c), 32'(tx), 32'd1);
            check($sformatf("quiet busy c=%0d", c), 32'(busy), 32'd0);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
